// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction, ALU-control and writeback bundle for alu_sequencer
interface alu_sequencer_if;
    // instruction handshake from the decoder
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    // control word to the combinational ALU and its result
    logic [2:0] input_1_select;
    logic [2:0] input_2_select;
    logic [7:0] alu_opcode;
    logic       cin;
    logic [7:0] alu_data;
    logic [7:0] alu_out;
    logic       alu_cout;
    // register writeback and status
    logic       wb_en;
    logic [1:0] wb_dest;
    logic [7:0] wb_value;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       done;
    logic       illegal;

    // decoder / ALU / register-file side
    modport master (
        output instr_valid, instr_opcode, instr_operand, alu_out, alu_cout,
        input  instr_ready, input_1_select, input_2_select, alu_opcode, cin, alu_data,
        input  wb_en, wb_dest, wb_value, flag_n, flag_z, flag_c, done, illegal
    );

    // sequencer side
    modport slave (
        input  instr_valid, instr_opcode, instr_operand, alu_out, alu_cout,
        output instr_ready, input_1_select, input_2_select, alu_opcode, cin, alu_data,
        output wb_en, wb_dest, wb_value, flag_n, flag_z, flag_c, done, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 3-cycle 6502 accumulator/register instruction sequencer driving an external ALU
module alu_sequencer #(
    parameter logic [2:0] RESET_FLAGS = 3'b000   // {N,Z,C} after reset
) (
    input  logic          clk,
    input  logic          rst,
    alu_sequencer_if.slave bus
);

    // ALU operand select encoding
    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_A    = 3'd1;
    localparam logic [2:0] SEL_X    = 3'd2;
    localparam logic [2:0] SEL_Y    = 3'd3;
    localparam logic [2:0] SEL_DATA = 3'd4;
    localparam logic [2:0] SEL_ONE  = 3'd6;

    // ALU operation encoding
    localparam logic [7:0] OP_NONE = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ASL  = 8'h11;
    localparam logic [7:0] OP_ROL  = 8'h12;
    localparam logic [7:0] OP_ASR  = 8'h13;
    localparam logic [7:0] OP_ROR  = 8'h14;
    localparam logic [7:0] OP_ADD  = 8'h21;
    localparam logic [7:0] OP_INC  = 8'h22;
    localparam logic [7:0] OP_SUB  = 8'h23;
    localparam logic [7:0] OP_DEC  = 8'h24;

    // writeback destinations
    localparam logic [1:0] DST_A = 2'd0;
    localparam logic [1:0] DST_X = 2'd1;
    localparam logic [1:0] DST_Y = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // decoded control word for the opcode currently on the handshake
    logic [2:0] w_sel1;
    logic [2:0] w_sel2;
    logic [7:0] w_op;
    logic       w_cin;
    logic       w_wb;
    logic [1:0] w_dest;
    logic       w_upd_nz;
    logic       w_upd_c;
    logic       w_set_c;
    logic       w_clr_c;
    logic       w_illegal;

    // FSM-derived strobes
    logic       w_accept;
    logic       w_capture;
    logic       w_ready;
    logic       w_done;
    logic       w_wb_en;
    logic       w_ill_out;

    // registered control word and per-instruction bookkeeping
    logic [2:0] r_sel1;
    logic [2:0] r_sel2;
    logic [7:0] r_op;
    logic       r_cin;
    logic [7:0] r_alu_data;
    logic       r_wb_pend;
    logic [1:0] r_dest_pend;
    logic       r_upd_nz;
    logic       r_upd_c;
    logic       r_set_c;
    logic       r_clr_c;
    logic       r_ill_pend;

    // architectural outputs that hold between instructions
    logic [7:0] r_wb_value;
    logic [1:0] r_wb_dest;
    logic       r_n;
    logic       r_z;
    logic       r_c;

    // decode the offered opcode; carry-in for ADC/SBC/ROL/ROR comes from the live C flag
    always_comb begin
        w_sel1    = SEL_NONE;
        w_sel2    = SEL_NONE;
        w_op      = OP_NONE;
        w_cin     = 1'b0;
        w_wb      = 1'b0;
        w_dest    = DST_A;
        w_upd_nz  = 1'b0;
        w_upd_c   = 1'b0;
        w_set_c   = 1'b0;
        w_clr_c   = 1'b0;
        w_illegal = 1'b0;
        case (bus.instr_opcode)
            8'h69: begin // ADC #
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_ADD; w_cin = r_c;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'hE9: begin // SBC #
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_SUB; w_cin = r_c;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'h29: begin // AND #
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_AND;
                w_wb = 1'b1; w_upd_nz = 1'b1;
            end
            8'h09: begin // ORA #
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_OR;
                w_wb = 1'b1; w_upd_nz = 1'b1;
            end
            8'h49: begin // EOR #
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_XOR;
                w_wb = 1'b1; w_upd_nz = 1'b1;
            end
            8'hC9: begin // CMP # : subtract with no borrow-in, flags only
                w_sel1 = SEL_A; w_sel2 = SEL_DATA; w_op = OP_SUB; w_cin = 1'b1;
                w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'h0A: begin // ASL A
                w_sel1 = SEL_A; w_op = OP_ASL;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'h4A: begin // LSR A maps onto ASR with a zero fill
                w_sel1 = SEL_A; w_op = OP_ASR;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'h2A: begin // ROL A
                w_sel1 = SEL_A; w_op = OP_ROL; w_cin = r_c;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'h6A: begin // ROR A
                w_sel1 = SEL_A; w_op = OP_ROR; w_cin = r_c;
                w_wb = 1'b1; w_upd_nz = 1'b1; w_upd_c = 1'b1;
            end
            8'hE8: begin // INX
                w_sel1 = SEL_X; w_sel2 = SEL_ONE; w_op = OP_INC;
                w_wb = 1'b1; w_dest = DST_X; w_upd_nz = 1'b1;
            end
            8'hC8: begin // INY
                w_sel1 = SEL_Y; w_sel2 = SEL_ONE; w_op = OP_INC;
                w_wb = 1'b1; w_dest = DST_Y; w_upd_nz = 1'b1;
            end
            8'hCA: begin // DEX
                w_sel1 = SEL_X; w_sel2 = SEL_ONE; w_op = OP_DEC;
                w_wb = 1'b1; w_dest = DST_X; w_upd_nz = 1'b1;
            end
            8'h88: begin // DEY
                w_sel1 = SEL_Y; w_sel2 = SEL_ONE; w_op = OP_DEC;
                w_wb = 1'b1; w_dest = DST_Y; w_upd_nz = 1'b1;
            end
            8'h18: w_clr_c = 1'b1; // CLC
            8'h38: w_set_c = 1'b1; // SEC
            default: w_illegal = 1'b1;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and handshake/strobe outputs
    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_done    = 1'b0;
        w_wb_en   = 1'b0;
        w_ill_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture = 1'b1;
                w_next    = S_WB;
            end
            S_WB: begin
                w_done    = 1'b1;
                w_wb_en   = r_wb_pend;
                w_ill_out = r_ill_pend;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // latch the control word on accept; drop it once EXEC ends so the ALU sees zeros outside EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel1      <= SEL_NONE;
            r_sel2      <= SEL_NONE;
            r_op        <= OP_NONE;
            r_cin       <= 1'b0;
            r_alu_data  <= 8'h00;
            r_wb_pend   <= 1'b0;
            r_dest_pend <= DST_A;
            r_upd_nz    <= 1'b0;
            r_upd_c     <= 1'b0;
            r_set_c     <= 1'b0;
            r_clr_c     <= 1'b0;
            r_ill_pend  <= 1'b0;
        end else if (w_accept) begin
            r_sel1      <= w_sel1;
            r_sel2      <= w_sel2;
            r_op        <= w_op;
            r_cin       <= w_cin;
            r_alu_data  <= bus.instr_operand;
            r_wb_pend   <= w_wb;
            r_dest_pend <= w_dest;
            r_upd_nz    <= w_upd_nz;
            r_upd_c     <= w_upd_c;
            r_set_c     <= w_set_c;
            r_clr_c     <= w_clr_c;
            r_ill_pend  <= w_illegal;
        end else if (w_capture) begin
            r_sel1 <= SEL_NONE;
            r_sel2 <= SEL_NONE;
            r_op   <= OP_NONE;
            r_cin  <= 1'b0;
        end
    end

    // capture ALU result and update flags on the EXEC->WB edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_value <= 8'h00;
            r_wb_dest  <= DST_A;
            r_n        <= RESET_FLAGS[2];
            r_z        <= RESET_FLAGS[1];
            r_c        <= RESET_FLAGS[0];
        end else if (w_capture) begin
            if (r_wb_pend) begin
                r_wb_value <= bus.alu_out;
                r_wb_dest  <= r_dest_pend;
            end
            if (r_upd_nz) begin
                r_n <= bus.alu_out[7];
                r_z <= (bus.alu_out == 8'h00);
            end
            if (r_upd_c) begin
                r_c <= bus.alu_cout;
            end else if (r_set_c) begin
                r_c <= 1'b1;
            end else if (r_clr_c) begin
                r_c <= 1'b0;
            end
        end
    end

    assign bus.instr_ready    = w_ready;
    assign bus.input_1_select = r_sel1;
    assign bus.input_2_select = r_sel2;
    assign bus.alu_opcode     = r_op;
    assign bus.cin            = r_cin;
    assign bus.alu_data       = r_alu_data;
    assign bus.wb_en          = w_wb_en;
    assign bus.wb_dest        = r_wb_dest;
    assign bus.wb_value       = r_wb_value;
    assign bus.flag_n         = r_n;
    assign bus.flag_z         = r_z;
    assign bus.flag_c         = r_c;
    assign bus.done           = w_done;
    assign bus.illegal        = w_ill_out;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU and register file
module tb_alu_sequencer;

    localparam logic [2:0] RF = 3'b101;

    typedef struct packed {
        logic       wb;
        logic [1:0] dest;
        logic [7:0] val;
        logic [2:0] nzc;
        logic       ill;
    } exp_t;

    logic clk;
    logic rst;
    alu_sequencer_if u_if ();

    alu_sequencer #(.RESET_FLAGS(RF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q[$];
    exp_t e;

    // bench register file and its preload port
    logic [7:0] rf_a, rf_x, rf_y;
    logic       ld_req;
    logic [1:0] ld_dst;
    logic [7:0] ld_val;

    // architectural reference state
    logic [7:0] m_a, m_x, m_y;
    logic       m_n, m_z, m_c;
    time        last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // register file: DUT writeback, else bench preload
    always @(posedge clk) begin
        if (u_if.wb_en === 1'b1) begin
            case (u_if.wb_dest)
                2'd0: rf_a <= u_if.wb_value;
                2'd1: rf_x <= u_if.wb_value;
                2'd2: rf_y <= u_if.wb_value;
                default: ;
            endcase
        end else if (ld_req) begin
            case (ld_dst)
                2'd0: rf_a <= ld_val;
                2'd1: rf_x <= ld_val;
                default: rf_y <= ld_val;
            endcase
        end
    end

    // behavioural ALU
    logic [7:0] alu_a, alu_b;
    logic [8:0] alu_t;
    always_comb begin
        case (u_if.input_1_select)
            3'd1: alu_a = rf_a;   3'd2: alu_a = rf_x;   3'd3: alu_a = rf_y;
            3'd4: alu_a = u_if.alu_data; 3'd5: alu_a = 8'hFD; 3'd6: alu_a = 8'h01;
            default: alu_a = 8'h00;
        endcase
        case (u_if.input_2_select)
            3'd1: alu_b = rf_a;   3'd2: alu_b = rf_x;   3'd3: alu_b = rf_y;
            3'd4: alu_b = u_if.alu_data; 3'd5: alu_b = 8'hFD; 3'd6: alu_b = 8'h01;
            default: alu_b = 8'h00;
        endcase
        alu_t = 9'h000;
        case (u_if.alu_opcode)
            8'h01: alu_t = {1'b0, alu_a & alu_b};
            8'h02: alu_t = {1'b0, alu_a | alu_b};
            8'h03: alu_t = {1'b0, alu_a ^ alu_b};
            8'h11: alu_t = {alu_a[7], alu_a[6:0], 1'b0};
            8'h12: alu_t = {alu_a[7], alu_a[6:0], u_if.cin};
            8'h13: alu_t = {alu_a[0], u_if.cin, alu_a[7:1]};
            8'h14: alu_t = {alu_a[0], u_if.cin, alu_a[7:1]};
            8'h21: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, u_if.cin};
            8'h22: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            8'h23: alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, u_if.cin};
            8'h24: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_t = 9'h000;
        endcase
        u_if.alu_out  = alu_t[7:0];
        u_if.alu_cout = alu_t[8];
    end

    // scoreboard: compare every completion against the oldest expectation
    always @(negedge clk) begin
        if (u_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", u_if.done, 0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_en", u_if.wb_en, e.wb);
                chk("illegal", u_if.illegal, e.ill);
                if (e.wb) begin
                    chk("wb_dest", u_if.wb_dest, e.dest);
                    chk("wb_value", u_if.wb_value, e.val);
                end
                chk("flags_nzc", {u_if.flag_n, u_if.flag_z, u_if.flag_c}, e.nzc);
            end
        end
    end

    task automatic preload(input logic [1:0] dst, input logic [7:0] val);
        @(negedge clk);
        ld_req = 1'b1; ld_dst = dst; ld_val = val;
        @(posedge clk);
        #1 ld_req = 1'b0;
        case (dst)
            2'd0: m_a = val;
            2'd1: m_x = val;
            default: m_y = val;
        endcase
    endtask

    // expected {sel1, sel2, op, cin} straight from the decode table
    function automatic logic [14:0] exp_ctrl(input logic [7:0] op, input logic c);
        case (op)
            8'h69: return {3'd1, 3'd4, 8'h21, c};
            8'hE9: return {3'd1, 3'd4, 8'h23, c};
            8'h29: return {3'd1, 3'd4, 8'h01, 1'b0};
            8'h09: return {3'd1, 3'd4, 8'h02, 1'b0};
            8'h49: return {3'd1, 3'd4, 8'h03, 1'b0};
            8'hC9: return {3'd1, 3'd4, 8'h23, 1'b1};
            8'h0A: return {3'd1, 3'd0, 8'h11, 1'b0};
            8'h4A: return {3'd1, 3'd0, 8'h13, 1'b0};
            8'h2A: return {3'd1, 3'd0, 8'h12, c};
            8'h6A: return {3'd1, 3'd0, 8'h14, c};
            8'hE8: return {3'd2, 3'd6, 8'h22, 1'b0};
            8'hC8: return {3'd3, 3'd6, 8'h22, 1'b0};
            8'hCA: return {3'd2, 3'd6, 8'h24, 1'b0};
            8'h88: return {3'd3, 3'd6, 8'h24, 1'b0};
            default: return 15'h0000;
        endcase
    endfunction

    // offer one instruction, push its expected outcome, and follow it to WB
    task automatic issue(input logic [7:0] op, input logic [7:0] opd, input bit keep, input bit btb);
        exp_t       x;
        logic [8:0] t;
        logic [7:0] r;
        logic       oc, nz;
        logic [14:0] ctl;
        int         w, n;
        u_if.instr_opcode  = op;
        u_if.instr_operand = opd;
        u_if.instr_valid   = 1'b1;
        w = 0;
        while (u_if.instr_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", u_if.instr_ready, 1);
        @(posedge clk);
        if (btb) chk("btb_gap", 32'(($time - last_acc) / 10), 3);
        last_acc = $time;
        ctl = exp_ctrl(op, m_c);
        oc = m_c; nz = 1'b1; r = 8'h00;
        x = '0;
        case (op)
            8'h69: begin t = {1'b0, m_a} + {1'b0, opd} + {8'h00, oc}; r = t[7:0]; m_c = t[8]; x.wb = 1; end
            8'hE9: begin t = {1'b0, m_a} + {1'b0, ~opd} + {8'h00, oc}; r = t[7:0]; m_c = t[8]; x.wb = 1; end
            8'hC9: begin t = {1'b0, m_a} + {1'b0, ~opd} + 9'd1; r = t[7:0]; m_c = t[8]; end
            8'h29: begin r = m_a & opd; x.wb = 1; end
            8'h09: begin r = m_a | opd; x.wb = 1; end
            8'h49: begin r = m_a ^ opd; x.wb = 1; end
            8'h0A: begin r = {m_a[6:0], 1'b0}; m_c = m_a[7]; x.wb = 1; end
            8'h4A: begin r = {1'b0, m_a[7:1]}; m_c = m_a[0]; x.wb = 1; end
            8'h2A: begin r = {m_a[6:0], oc}; m_c = m_a[7]; x.wb = 1; end
            8'h6A: begin r = {oc, m_a[7:1]}; m_c = m_a[0]; x.wb = 1; end
            8'hE8: begin r = m_x + 8'd1; x.wb = 1; x.dest = 2'd1; end
            8'hC8: begin r = m_y + 8'd1; x.wb = 1; x.dest = 2'd2; end
            8'hCA: begin r = m_x - 8'd1; x.wb = 1; x.dest = 2'd1; end
            8'h88: begin r = m_y - 8'd1; x.wb = 1; x.dest = 2'd2; end
            8'h18: begin m_c = 1'b0; nz = 1'b0; end
            8'h38: begin m_c = 1'b1; nz = 1'b0; end
            default: begin x.ill = 1'b1; nz = 1'b0; end
        endcase
        if (nz) begin m_n = r[7]; m_z = (r == 8'h00); end
        if (x.wb) begin
            case (x.dest)
                2'd0: m_a = r;
                2'd1: m_x = r;
                default: m_y = r;
            endcase
        end
        x.val = r;
        x.nzc = {m_n, m_z, m_c};
        sb_q.push_back(x);
        #1;
        if (!keep) u_if.instr_valid = 1'b0;
        u_if.instr_opcode  = 8'h69;
        u_if.instr_operand = 8'hA5;
        n = 0;
        while (n < 6) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("exec_ctrl", {u_if.input_1_select, u_if.input_2_select, u_if.alu_opcode, u_if.cin}, ctl);
                chk("exec_data", u_if.alu_data, opd);
                chk("exec_ready", u_if.instr_ready, 0);
            end
            if (u_if.done === 1'b1) break;
        end
        chk("done_latency", n, 2);
        chk("wb_ready", u_if.instr_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        ld_req = 1'b0; ld_dst = 2'd0; ld_val = 8'h00;
        u_if.instr_valid = 1'b0; u_if.instr_opcode = 8'h00; u_if.instr_operand = 8'h00;
        rf_a = 8'h00; rf_x = 8'h00; rf_y = 8'h00;
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
        {m_n, m_z, m_c} = RF;
        last_acc = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", u_if.instr_ready, 1);
        chk("rst_ctrl", {u_if.input_1_select, u_if.input_2_select, u_if.alu_opcode, u_if.cin}, 0);
        chk("rst_wb", {u_if.wb_en, u_if.done, u_if.illegal, u_if.wb_dest, u_if.wb_value}, 0);
        chk("rst_flags", {u_if.flag_n, u_if.flag_z, u_if.flag_c}, RF);
        rst = 1'b0;

        issue(8'h18, 8'h00, 0, 0);              // CLC
        preload(2'd0, 8'h01);
        issue(8'h69, 8'h04, 0, 0);              // ADC #04 -> 05
        issue(8'h38, 8'h00, 0, 0);              // SEC
        preload(2'd0, 8'h00);
        issue(8'hE9, 8'h01, 0, 0);              // SBC #01 -> FF, C=0
        preload(2'd0, 8'h05);
        issue(8'hC9, 8'h05, 0, 0);              // CMP #05 -> Z=1, C=1
        preload(2'd1, 8'hFF);
        issue(8'hE8, 8'h00, 0, 0);              // INX -> 00
        preload(2'd2, 8'h10);
        issue(8'h88, 8'h00, 0, 0);              // DEY -> 0F
        issue(8'hC8, 8'h00, 0, 0);              // INY -> 10
        issue(8'hCA, 8'h00, 0, 0);              // DEX -> FF
        preload(2'd0, 8'h81);
        issue(8'h0A, 8'h00, 0, 0);              // ASL
        issue(8'h2A, 8'h00, 0, 0);              // ROL
        issue(8'h6A, 8'h00, 0, 0);              // ROR
        issue(8'h4A, 8'h00, 0, 0);              // LSR
        preload(2'd0, 8'h3C);
        issue(8'h29, 8'h0F, 0, 0);              // AND
        issue(8'h09, 8'hF0, 0, 0);              // ORA
        issue(8'h49, 8'hFF, 0, 0);              // EOR
        issue(8'hFF, 8'h00, 0, 0);              // illegal
        for (int i = 0; i < 6; i++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
        end
        issue(8'hFF, 8'h12, 1, 0);              // back-to-back train
        issue(8'h69, 8'h33, 1, 1);
        issue(8'h6A, 8'h00, 1, 1);
        issue(8'hE8, 8'h00, 0, 1);
        repeat (2) @(negedge clk);

        // reset while an ADC is in EXEC: nothing may complete
        u_if.instr_opcode = 8'h69; u_if.instr_operand = 8'h44; u_if.instr_valid = 1'b1;
        @(posedge clk);
        #1 u_if.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", u_if.instr_ready, 1);
        chk("mid_rst_ctrl", {u_if.input_1_select, u_if.input_2_select, u_if.alu_opcode, u_if.cin, u_if.alu_data}, 0);
        chk("mid_rst_wb", {u_if.wb_en, u_if.done, u_if.illegal, u_if.wb_dest, u_if.wb_value}, 0);
        chk("mid_rst_flags", {u_if.flag_n, u_if.flag_z, u_if.flag_c}, RF);
        {m_n, m_z, m_c} = RF;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_wb", {u_if.wb_en, u_if.done}, 0);
        end
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
